// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch queue and its storage array.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RV32I_NOP = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Ceiling log2, used for pointer and occupancy widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fetchq_storage.sv
// DEPTH-entry {pc, instr} register array: synchronous write, asynchronous read.
module fetchq_storage
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);

    // Contents are don't-care after reset, so the array carries no reset.
    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode; drives StallF with skid room.
// Optional same-cycle empty-queue bypass is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue
    import rv32i_pkg::*;
#(
    parameter int             DEPTH     = 4,
    parameter int             SKID      = 1,
    parameter logic [XLEN-1:0] NOP_INSTR = RV32I_NOP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    input  logic [XLEN-1:0]         in_pc_i,
    input  logic [XLEN-1:0]         in_instr_i,
    output logic                    stall_f_o,
    output logic                    out_valid_o,
    output logic [XLEN-1:0]         out_pc_o,
    output logic [XLEN-1:0]         out_pc4_o,
    output logic [XLEN-1:0]         out_instr_o,
    input  logic                    out_ready_i,
    output logic [clog2(DEPTH):0]   count_o,
    output logic                    ovf_err_o
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] SKID_C  = CW'(SKID);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic          full;
    logic          empty;
    logic          enq;
    logic          deq;
    fetch_entry_t  wentry;
    fetch_entry_t  head;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Only stored entries are dequeued; a bypassed entry never touches rd_ptr.
    assign deq = !empty && out_ready_i && !flush_i;

`ifdef FETCHQ_BYPASS_EN
    logic bypass;
    assign bypass      = empty && in_valid_i && !flush_i;
    assign enq         = in_valid_i && !full && !flush_i && !(bypass && out_ready_i);
    assign out_valid_o = !empty || bypass;
`else
    assign enq         = in_valid_i && !full && !flush_i;
    assign out_valid_o = !empty;
`endif

    assign wentry.pc    = in_pc_i;
    assign wentry.instr = in_instr_i;

    fetchq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk   (clk),
        .we    (enq),
        .waddr (wr_ptr),
        .wdata (wentry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ovf_err_o <= 1'b0;
        end else begin
            if (in_valid_i && full && !flush_i) ovf_err_o <= 1'b1;
            if (flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + 1'b1;
                if (deq) rd_ptr <= rd_ptr + 1'b1;
                case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_comb begin
        out_pc_o    = '0;
        out_instr_o = NOP_INSTR;
        if (!empty) begin
            out_pc_o    = head.pc;
            out_instr_o = head.instr;
        end
`ifdef FETCHQ_BYPASS_EN
        else if (bypass) begin
            out_pc_o    = in_pc_i;
            out_instr_o = in_instr_i;
        end
`endif
    end

    assign out_pc4_o = out_pc_o + 32'd4;

    // StallF leaves SKID slots free for responses already in flight.
    assign free      = DEPTH_C - count;
    assign stall_f_o = (free <= SKID_C);
    assign count_o   = count;

endmodule
